// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage CPU pipeline control blocks.
package cpu_pkg;

    localparam int REG_W = 4;
    localparam int DRAIN_CYC_DEF = 3;
    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] OP_NOP = 4'h0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: decode/execute hazard inputs and pipeline-register controls.
interface hazard_ctrl_if #(
    parameter int REG_W = cpu_pkg::REG_W,
    parameter int CNT_W = cpu_pkg::CNT_W_DEF
);
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             ifid_use_rs;
    logic             ifid_use_rt;
    logic             ifid_halt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rd;
    logic             br_taken;

    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_halt,
               idex_memread, idex_rd, br_taken,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_use_rs, ifid_use_rt, ifid_halt,
               idex_memread, idex_rd, br_taken,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by rst_n.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch squash and HLT drain control for the IF/ID and ID/EX registers.
// Controls are combinational from the registered state so they act in the same cycle.
module hazard_ctrl #(
    parameter int REG_W     = cpu_pkg::REG_W,
    parameter int DRAIN_CYC = cpu_pkg::DRAIN_CYC_DEF,
    parameter int CNT_W     = cpu_pkg::CNT_W_DEF
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    import cpu_pkg::*;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    hz_state_e     state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [REG_W-1:0] rs, rt, rd;
    logic             lu;
    logic             stall_inc, flush_inc;
    logic             pc_wen_c, ifid_wen_c, ifid_flush_c, idex_wen_c, idex_bubble_c;

    assign rs = hz.ifid_rs;
    assign rt = hz.ifid_rt;
    assign rd = hz.idex_rd;

    // r0 is hardwired zero, so a load targeting it can never feed a dependent.
    assign lu = hz.idex_memread && (rd != '0) &&
                ((hz.ifid_use_rs && (rs == rd)) || (hz.ifid_use_rt && (rt == rd)));

    always_comb begin
        pc_wen_c      = 1'b0;
        ifid_wen_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_wen_c    = 1'b0;
        idex_bubble_c = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;
        drain_d       = drain_q;

        if (!rst_n) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.br_taken) begin
                        pc_wen_c      = 1'b1;
                        ifid_wen_c    = 1'b1;
                        ifid_flush_c  = 1'b1;
                        idex_wen_c    = 1'b1;
                        idex_bubble_c = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (lu) begin
                        idex_wen_c    = 1'b1;
                        idex_bubble_c = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (hz.ifid_halt) begin
                        idex_wen_c = 1'b1;
                        state_d    = DRAIN;
                        drain_d    = DRAIN_LOAD;
                    end else begin
                        pc_wen_c   = 1'b1;
                        ifid_wen_c = 1'b1;
                        idex_wen_c = 1'b1;
                    end
                end
                DRAIN: begin
                    // A redirect here cannot happen in a correct program; recover as a normal flush.
                    if (hz.br_taken) begin
                        pc_wen_c      = 1'b1;
                        ifid_wen_c    = 1'b1;
                        ifid_flush_c  = 1'b1;
                        idex_wen_c    = 1'b1;
                        idex_bubble_c = 1'b1;
                        flush_inc     = 1'b1;
                        state_d       = RUN;
                        drain_d       = '0;
                    end else begin
                        idex_wen_c    = 1'b1;
                        idex_bubble_c = 1'b1;
                        if (drain_q == '0) begin
                            state_d = HALTED;
                        end else begin
                            drain_d = drain_q - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_inc),
        .count_o (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_inc),
        .count_o (hz.flush_cnt)
    );

    assign hz.pc_wen      = pc_wen_c;
    assign hz.ifid_wen    = ifid_wen_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_wen    = idex_wen_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.halted      = (state_q == HALTED);
endmodule
